// File: rtl/i2c_target.sv
// i2c_target: I2C target answering one 7-bit address, with a 16-bit read source and a byte-wide write sink.
module i2c_target #(
    parameter logic [6:0] I2C_ADDR    = 7'h4B,
    parameter int         SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        SCL,
    inout  wire         SDA,
    input  logic [15:0] rd_data,
    output logic        rd_req,
    output logic [7:0]  wr_data,
    output logic        wr_valid,
    output logic        busy
);
    typedef enum logic [2:0] {IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, WAIT_STOP} state_t;

    state_t             state_q, state_d;
    logic [SYNC_STAGES:0] scl_q, sda_q;
    logic [2:0]         cnt_q, cnt_d;
    logic [6:0]         sh_q, sh_d;
    logic [15:0]        rd_sh_q, rd_sh_d;
    logic [7:0]         wr_data_q, wr_data_d;
    logic               oe_q, oe_d, busy_q, busy_d, rw_q, rw_d;
    logic               rd_req_q, rd_req_d, wr_valid_q, wr_valid_d;
    logic               scl, scl_p, sda, sda_p, scl_rise, scl_fall, start, stop;
    logic [7:0]         byte_in;

    // Top stage is the previous synchronized value, used only for edge detection
    assign scl      = scl_q[SYNC_STAGES-1];
    assign scl_p    = scl_q[SYNC_STAGES];
    assign sda      = sda_q[SYNC_STAGES-1];
    assign sda_p    = sda_q[SYNC_STAGES];
    assign scl_rise = scl & ~scl_p;
    assign scl_fall = ~scl & scl_p;
    assign start    = scl & scl_p & sda_p & ~sda;
    assign stop     = scl & scl_p & ~sda_p & sda;
    assign byte_in  = {sh_q, sda};

    assign SDA      = oe_q ? 1'b0 : 1'bz;
    assign rd_req   = rd_req_q;
    assign wr_data  = wr_data_q;
    assign wr_valid = wr_valid_q;
    assign busy     = busy_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sh_d       = sh_q;
        rd_sh_d    = rd_sh_q;
        oe_d       = oe_q;
        busy_d     = busy_q;
        rw_d       = rw_q;
        wr_data_d  = wr_data_q;
        rd_req_d   = 1'b0;
        wr_valid_d = 1'b0;
        if (stop) begin
            state_d = IDLE;
            oe_d    = 1'b0;
            busy_d  = 1'b0;
        end else if (start) begin
            state_d = ADDR;
            cnt_d   = 3'd0;
            oe_d    = 1'b0;
            busy_d  = 1'b1;
        end else begin
            case (state_q)
                ADDR: if (scl_rise) begin
                    sh_d  = byte_in[6:0];
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        if (byte_in[7:1] == I2C_ADDR) begin
                            state_d  = ADDR_ACK;
                            rw_d     = sda;
                            rd_req_d = sda;
                            rd_sh_d  = sda ? rd_data : rd_sh_q;
                        end else begin
                            state_d = WAIT_STOP;
                            busy_d  = 1'b0;
                        end
                    end
                end
                // First fall drives ACK, second fall ends the ACK clock
                ADDR_ACK, WR_ACK: if (scl_fall) begin
                    oe_d = 1'b1;
                    if (oe_q) begin
                        state_d = (state_q == ADDR_ACK && rw_q) ? RD_BYTE : WR_BYTE;
                        oe_d    = (state_q == ADDR_ACK && rw_q) ? ~rd_sh_q[15] : 1'b0;
                    end
                end
                WR_BYTE: if (scl_rise) begin
                    sh_d  = byte_in[6:0];
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        wr_data_d  = byte_in;
                        wr_valid_d = 1'b1;
                        state_d    = WR_ACK;
                    end
                end
                // Ones shift in from the bottom so bytes past the second read 8'hFF
                RD_BYTE: if (scl_rise) cnt_d = cnt_q + 3'd1;
                else if (scl_fall) begin
                    rd_sh_d = {rd_sh_q[14:0], 1'b1};
                    oe_d    = (cnt_q != 3'd0) & ~rd_sh_q[14];
                    state_d = (cnt_q == 3'd0) ? RD_ACK : RD_BYTE;
                end
                RD_ACK: if (scl_rise && sda) state_d = WAIT_STOP;
                else if (scl_fall) begin
                    state_d = RD_BYTE;
                    oe_d    = ~rd_sh_q[15];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            scl_q      <= '1;
            sda_q      <= '1;
            cnt_q      <= 3'd0;
            sh_q       <= '1;
            rd_sh_q    <= '1;
            wr_data_q  <= 8'h00;
            oe_q       <= 1'b0;
            busy_q     <= 1'b0;
            rw_q       <= 1'b0;
            rd_req_q   <= 1'b0;
            wr_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            scl_q      <= {scl_q[SYNC_STAGES-1:0], SCL};
            sda_q      <= {sda_q[SYNC_STAGES-1:0], SDA};
            cnt_q      <= cnt_d;
            sh_q       <= sh_d;
            rd_sh_q    <= rd_sh_d;
            wr_data_q  <= wr_data_d;
            oe_q       <= oe_d;
            busy_q     <= busy_d;
            rw_q       <= rw_d;
            rd_req_q   <= rd_req_d;
            wr_valid_q <= wr_valid_d;
        end
    end
endmodule

// File: tb/tb_i2c_target.sv
// tb_i2c_target: bus-level initiator model with scoreboard queues for read bytes and write data.
module tb_i2c_target;
    localparam int Q = 50;
    logic        clk = 1'b0, rst_n = 1'b0, SCL = 1'b1, sda_drv = 1'b1;
    logic [15:0] rd_data = 16'h0000;
    logic        rd_req, wr_valid, busy;
    logic [7:0]  wr_data;
    wire         SDA;
    int          checks = 0, passed = 0, rd_req_cnt = 0;
    bit          watch_busy = 1'b0, busy_dropped = 1'b0;
    logic [7:0]  wr_obs_q[$], wr_exp_q[$], rd_exp_q[$];

    assign SDA = sda_drv ? 1'bz : 1'b0;
    pullup (SDA);
    always #5 clk = ~clk;

    i2c_target dut (.clk(clk), .rst_n(rst_n), .SCL(SCL), .SDA(SDA), .rd_data(rd_data),
                    .rd_req(rd_req), .wr_data(wr_data), .wr_valid(wr_valid), .busy(busy));

    always @(negedge clk) begin
        if (wr_valid) wr_obs_q.push_back(wr_data);
        if (rd_req) rd_req_cnt++;
        if (watch_busy && !busy) busy_dropped = 1'b1;
    end

    task automatic bit_tx(input logic b);
        sda_drv = b; #Q; SCL = 1'b1; #(2*Q); SCL = 1'b0; #Q;
    endtask

    task automatic bit_rx(output logic r);
        sda_drv = 1'b1; #Q; SCL = 1'b1; #Q; r = SDA; #Q; SCL = 1'b0; #Q;
    endtask

    task automatic i2c_start();
        sda_drv = 1'b1; #Q; SCL = 1'b1; #(2*Q); sda_drv = 1'b0; #(2*Q); SCL = 1'b0; #Q;
    endtask

    task automatic i2c_stop();
        sda_drv = 1'b0; #Q; SCL = 1'b1; #(2*Q); sda_drv = 1'b1; #(2*Q);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) bit_tx(b[i]);
        bit_rx(ack);
    endtask

    task automatic recv_byte(input logic ack_bit, output logic [7:0] b);
        logic r;
        for (int i = 0; i < 8; i++) begin
            bit_rx(r);
            b = {b[6:0], r};
        end
        bit_tx(ack_bit);
    endtask

    task automatic test_reset();
        #(4*Q);
        checks++; if (SDA !== 1'b1) $display("FAIL reset_sda got %b want 1", SDA); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
        checks++; if (rd_req !== 1'b0) $display("FAIL reset_rd_req got %b want 0", rd_req); else passed++;
        checks++; if (wr_valid !== 1'b0) $display("FAIL reset_wr_valid got %b want 0", wr_valid); else passed++;
        checks++; if (wr_data !== 8'h00) $display("FAIL reset_wr_data got %h want 00", wr_data); else passed++;
        rst_n = 1'b1; #(4*Q);
    endtask

    task automatic test_read();
        logic ack; logic [7:0] b, e;
        rd_data = 16'h1A2B; rd_req_cnt = 0;
        rd_exp_q.push_back(8'h1A); rd_exp_q.push_back(8'h2B);
        i2c_start();
        send_byte(8'h97, ack);
        checks++; if (ack !== 1'b0) $display("FAIL read_addr_ack got %b want 0", ack); else passed++;
        for (int i = 0; i < 2; i++) begin
            recv_byte(i == 1, b);
            e = rd_exp_q.pop_front();
            checks++; if (b !== e) $display("FAIL read_byte%0d got %h want %h", i, b, e); else passed++;
        end
        checks++; if (busy !== 1'b1) $display("FAIL read_busy_before_stop got %b want 1", busy); else passed++;
        i2c_stop(); #Q;
        checks++; if (busy !== 1'b0) $display("FAIL read_busy_after_stop got %b want 0", busy); else passed++;
        checks++; if (rd_req_cnt !== 1) $display("FAIL read_rd_req_pulses got %0d want 1", rd_req_cnt); else passed++;
    endtask

    task automatic test_addr_nack();
        logic ack;
        rd_req_cnt = 0;
        i2c_start();
        send_byte(8'h95, ack);
        checks++; if (ack !== 1'b1) $display("FAIL nack_addr_ack got %b want 1", ack); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL nack_busy got %b want 0", busy); else passed++;
        bit_tx(1'b0); bit_tx(1'b1);
        checks++; if (busy !== 1'b0) $display("FAIL nack_busy_later got %b want 0", busy); else passed++;
        i2c_stop(); #Q;
        checks++; if (rd_req_cnt !== 0 || wr_obs_q.size() !== 0)
            $display("FAIL nack_no_strobes got rd_req=%0d wr=%0d want 0 0", rd_req_cnt, wr_obs_q.size());
        else passed++;
    endtask

    task automatic test_write();
        logic ack; logic [7:0] d[2] = '{8'h5C, 8'hA3};
        i2c_start();
        send_byte(8'h96, ack);
        checks++; if (ack !== 1'b0) $display("FAIL write_addr_ack got %b want 0", ack); else passed++;
        for (int i = 0; i < 2; i++) begin
            wr_exp_q.push_back(d[i]);
            send_byte(d[i], ack);
            checks++; if (ack !== 1'b0) $display("FAIL write_data_ack%0d got %b want 0", i, ack); else passed++;
        end
        i2c_stop(); #Q;
        checks++; if (wr_obs_q.size() !== 2) $display("FAIL write_count got %0d want 2", wr_obs_q.size()); else passed++;
        while (wr_obs_q.size() > 0 && wr_exp_q.size() > 0) begin
            logic [7:0] o, e;
            o = wr_obs_q.pop_front(); e = wr_exp_q.pop_front();
            checks++; if (o !== e) $display("FAIL write_data got %h want %h", o, e); else passed++;
        end
        wr_obs_q.delete(); wr_exp_q.delete();
    endtask

    task automatic test_back_to_back();
        logic ack; logic [7:0] b, e, o;
        rd_data = 16'hBEEF;
        rd_exp_q.push_back(8'hBE); rd_exp_q.push_back(8'hEF); rd_exp_q.push_back(8'hFF);
        i2c_start();
        watch_busy = 1'b1; busy_dropped = 1'b0;
        send_byte(8'h96, ack);
        wr_exp_q.push_back(8'h01);
        send_byte(8'h01, ack);
        checks++; if (ack !== 1'b0) $display("FAIL rs_write_ack got %b want 0", ack); else passed++;
        i2c_start();
        send_byte(8'h97, ack);
        checks++; if (ack !== 1'b0) $display("FAIL rs_read_addr_ack got %b want 0", ack); else passed++;
        for (int i = 0; i < 3; i++) begin
            recv_byte(i == 2, b);
            e = rd_exp_q.pop_front();
            checks++; if (b !== e) $display("FAIL rs_read_byte%0d got %h want %h", i, b, e); else passed++;
        end
        watch_busy = 1'b0;
        checks++; if (busy_dropped !== 1'b0) $display("FAIL rs_busy_dropped got %b want 0", busy_dropped); else passed++;
        i2c_stop(); #Q;
        o = (wr_obs_q.size() > 0) ? wr_obs_q.pop_front() : 8'hxx;
        e = wr_exp_q.pop_front();
        checks++; if (o !== e) $display("FAIL rs_write_data got %h want %h", o, e); else passed++;
        wr_obs_q.delete();
    endtask

    task automatic test_partial_stop();
        logic ack; logic [7:0] b, e;
        i2c_start();
        send_byte(8'h96, ack);
        for (int i = 0; i < 4; i++) bit_tx(i[0]);
        i2c_stop(); #Q;
        checks++; if (busy !== 1'b0) $display("FAIL partial_busy got %b want 0", busy); else passed++;
        checks++; if (wr_obs_q.size() !== 0) $display("FAIL partial_wr_valid got %0d want 0", wr_obs_q.size()); else passed++;
        rd_data = 16'h1234;
        rd_exp_q.push_back(8'h12); rd_exp_q.push_back(8'h34);
        i2c_start();
        send_byte(8'h97, ack);
        checks++; if (ack !== 1'b0) $display("FAIL partial_read_ack got %b want 0", ack); else passed++;
        for (int i = 0; i < 2; i++) begin
            recv_byte(i == 1, b);
            e = rd_exp_q.pop_front();
            checks++; if (b !== e) $display("FAIL partial_read_byte%0d got %h want %h", i, b, e); else passed++;
        end
        i2c_stop(); #Q;
    endtask

    task automatic test_reset_mid();
        logic ack, r; logic [7:0] o;
        rd_data = 16'h0000;
        i2c_start();
        send_byte(8'h97, ack);
        for (int i = 0; i < 3; i++) bit_rx(r);
        sda_drv = 1'b1; #Q;
        checks++; if (SDA !== 1'b0) $display("FAIL mid_sda_driven got %b want 0", SDA); else passed++;
        rst_n = 1'b0; #1;
        checks++; if (SDA !== 1'b1) $display("FAIL mid_sda_released got %b want 1", SDA); else passed++;
        checks++; if (busy !== 1'b0 || wr_data !== 8'h00)
            $display("FAIL mid_reset_outputs got busy=%b wr_data=%h want 0 00", busy, wr_data);
        else passed++;
        #19; rst_n = 1'b1;
        SCL = 1'b1; #(2*Q); SCL = 1'b0; #Q;
        i2c_stop();
        i2c_start();
        send_byte(8'h96, ack);
        checks++; if (ack !== 1'b0) $display("FAIL mid_next_ack got %b want 0", ack); else passed++;
        wr_exp_q.push_back(8'h77);
        send_byte(8'h77, ack);
        i2c_stop(); #Q;
        o = (wr_obs_q.size() > 0) ? wr_obs_q.pop_front() : 8'hxx;
        checks++; if (o !== wr_exp_q[0]) $display("FAIL mid_next_write got %h want %h", o, wr_exp_q[0]); else passed++;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_read();
        test_addr_nack();
        test_write();
        test_back_to_back();
        test_partial_stop();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/i2c_target.md
I2C_TARGET -- requirements
Module: i2c_target

Interface
REQ-001 SHALL have parameter I2C_ADDR, default 7'h4B, the 7-bit target address answered.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, the synchronizer depth on SCL and SDA inputs (legal range 2-3).
REQ-003 SHALL have port clk  input  1  system clock (100 MHz); all logic SHALL run on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset; one clock, asynchronous assert, active-low.
REQ-005 SHALL have port SCL  input  1  I2C clock from the initiator; no clock stretching.
REQ-006 SHALL have port SDA  inout  1  open-drain data; SDA SHALL be driven '0' when sda_oe=1, else 'z'.
REQ-007 SHALL have port rd_data  input  16  value returned on reads, MSB byte first.
REQ-008 SHALL have port rd_req  output  1  one-cycle pulse when a read address is ACKed; rd_data is latched in the same cycle.
REQ-009 SHALL have port wr_data  output  8  last byte received in a write transfer.
REQ-010 SHALL have port wr_valid  output  1  one-cycle pulse when wr_data updates.
REQ-011 SHALL have port busy  output  1  high from START detect to STOP detect or address NACK.

Function
REQ-012 SHALL pass SCL and SDA through SYNC_STAGES flops; all edges SHALL be detected on synchronized values only.
REQ-013 SHALL detect START as synchronized SDA 1->0 while SCL=1, and STOP as SDA 0->1 while SCL=1.
REQ-014 SHALL sample SDA on the synchronized SCL rising edge and change sda_oe only on the synchronized SCL falling edge.
REQ-015 SHALL implement states IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, WAIT_STOP.
REQ-016 IDLE: sda_oe=0; on START -> ADDR, bit counter cleared, busy=1.
REQ-017 ADDR: shift in 8 bits MSB first; after the 8th rising edge, compare bits[7:1] with I2C_ADDR.
REQ-018 Address match: at the next SCL fall drive ACK (sda_oe=1) in ADDR_ACK for exactly one SCL high period; mismatch: -> WAIT_STOP with SDA released (NACK) and busy=0.
REQ-019 Match with R/W=1: pulse rd_req and latch rd_data into a 16-bit shift register in the cycle the 8th bit is sampled; leaving ADDR_ACK on SCL fall -> RD_BYTE presenting bit 15.
REQ-020 RD_BYTE: sda_oe = ~current bit on each SCL fall; after 8 bits -> RD_ACK with SDA released.
REQ-021 RD_ACK: initiator SDA=0 (ACK) -> RD_BYTE with next byte; SDA=1 (NACK) -> WAIT_STOP.
REQ-022 Bytes beyond the second SHALL read as 8'hFF (SDA released).
REQ-023 Match with R/W=0: leaving ADDR_ACK -> WR_BYTE; after 8 bits, update wr_data, pulse wr_valid one cycle, -> WR_ACK driving ACK; then -> WR_BYTE.
REQ-024 STOP in any state SHALL force IDLE, release SDA, busy=0 within SYNC_STAGES+2 clocks.
REQ-025 START in any non-IDLE state (repeated start) SHALL restart at ADDR without asserting busy=0.
REQ-026 A bit counter SHALL be 3 bits wide and wrap from 7 to 0 at each byte boundary; an incomplete byte at STOP SHALL be discarded (no wr_valid).
REQ-027 SCL high and low phases of at least 8 clk cycles SHALL be supported; shorter phases are out of scope.
REQ-028 SCL SHALL never be driven by this block.

Reset
REQ-029 While rst_n=0: state=IDLE, sda_oe=0, busy=0, rd_req=0, wr_valid=0, wr_data=8'h00, shift registers and synchronizers set to 1 (bus idle).
REQ-030 Reset asserted mid-transfer SHALL release SDA asynchronously; after release the block SHALL ignore bus activity until the next START.

Verification
REQ-031 Read 0x4B (byte 0x97), rd_data=16'h1A2B, initiator ACKs byte 1 and NACKs byte 2 -> ACK on address, bytes 0x1A and 0x2B on SDA, rd_req single pulse, busy falls after STOP.
REQ-032 Address byte 0x95 (addr 0x4A) -> SDA stays released on the 9th clock, no rd_req/wr_valid, busy=0 until the next START.
REQ-033 Write 0x96 then 0x5C, 0xA3, STOP -> three ACKs, wr_valid pulses twice with wr_data 0x5C then 0xA3.
REQ-034 Write 0x96, 0x01, repeated START, read 0x97 with rd_data=16'hBEEF, reading 3 bytes -> 0xBE, 0xEF, 0xFF; busy stays 1 across the repeated start.
REQ-035 STOP after 4 bits of a write data byte -> IDLE, no wr_valid; next full read transfer completes correctly.
REQ-036 rst_n low during bit 3 of a read byte while SDA driven low -> SDA released same cycle, outputs at reset values; next transfer is answered normally.
